// File: rtl/data_port_arbiter.sv
// Two-requester arbiter for the single-port data SRAM.
// Requester 0 has priority; requester 1 is guaranteed a grant after MAX_WAIT denied cycles.
module data_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [BE_WIDTH-1:0]   m0_be,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [BE_WIDTH-1:0]   m1_be,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  sram_enable,
    output logic                  sram_write_enable,
    output logic [ADDR_WIDTH-1:0] sram_address,
    output logic [DATA_WIDTH-1:0] sram_write_data,
    output logic [BE_WIDTH-1:0]   sram_byte_enable,
    input  logic [DATA_WIDTH-1:0] sram_read_data
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;
    logic             rd_pending;
    logic             rd_owner;
    logic             m1_prio;
    logic             rd_grant;

    assign m1_prio = (wait_cnt == WAIT_LIMIT);

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m1_req && (m1_prio || !m0_req)) begin
                m1_gnt = 1'b1;
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end
        end
    end

    // Idle SRAM port drives zeros with all byte lanes enabled.
    always_comb begin
        sram_enable       = 1'b0;
        sram_write_enable = 1'b0;
        sram_address      = '0;
        sram_write_data   = '0;
        sram_byte_enable  = '1;
        if (m0_gnt) begin
            sram_enable       = 1'b1;
            sram_write_enable = m0_we;
            sram_address      = m0_addr;
            sram_write_data   = m0_wdata;
            sram_byte_enable  = m0_be;
        end else if (m1_gnt) begin
            sram_enable       = 1'b1;
            sram_write_enable = m1_we;
            sram_address      = m1_addr;
            sram_write_data   = m1_wdata;
            sram_byte_enable  = m1_be;
        end
    end

    assign rd_grant = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= '0;
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            rd_pending <= rd_grant;
            if (rd_grant) begin
                rd_owner <= m1_gnt;
            end
            if (!m1_req || m1_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // A response still in flight when reset arrives is dropped.
    assign m0_rvalid = ~rst & rd_pending & ~rd_owner;
    assign m1_rvalid = ~rst & rd_pending & rd_owner;
    assign m0_rdata  = m0_rvalid ? sram_read_data : '0;
    assign m1_rdata  = m1_rvalid ? sram_read_data : '0;

endmodule

// File: tb/tb_data_port_arbiter.sv
// Directed scoreboard bench for data_port_arbiter: grants, SRAM muxing,
// starvation bound, read routing and reset behaviour.
module tb_data_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        sram_enable, sram_write_enable;
    logic [31:0] sram_address, sram_write_data, sram_read_data;
    logic [3:0]  sram_byte_enable;

    typedef struct packed {
        logic        v0;
        logic        v1;
        logic [31:0] d;
    } resp_t;

    resp_t sb[$];
    int    checks = 0;
    int    errors = 0;

    data_port_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_be(m0_be), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_be(m1_be), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .sram_enable(sram_enable), .sram_write_enable(sram_write_enable),
        .sram_address(sram_address), .sram_write_data(sram_write_data),
        .sram_byte_enable(sram_byte_enable), .sram_read_data(sram_read_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
    endtask

    task automatic checkOutput(input logic eg0, input logic eg1, input resp_t cur);
        chk("m0_gnt", m0_gnt, eg0);
        chk("m1_gnt", m1_gnt, eg1);
        chk("m0_rvalid", m0_rvalid, cur.v0);
        chk("m1_rvalid", m1_rvalid, cur.v1);
        chk("m0_rdata", m0_rdata, cur.v0 ? cur.d : 32'h0);
        chk("m1_rdata", m1_rdata, cur.v1 ? cur.d : 32'h0);
        chk("sram_enable", sram_enable, eg0 | eg1);
        chk("sram_write_enable", sram_write_enable, eg0 ? m0_we : (eg1 ? m1_we : 1'b0));
        chk("sram_address", sram_address, eg0 ? m0_addr : (eg1 ? m1_addr : 32'h0));
        chk("sram_write_data", sram_write_data, eg0 ? m0_wdata : (eg1 ? m1_wdata : 32'h0));
        chk("sram_byte_enable", sram_byte_enable, eg0 ? m0_be : (eg1 ? m1_be : 4'hF));
    endtask

    // Inputs for the cycle are already driven; resp is what the SRAM returns next cycle.
    task automatic applyStimulus(input logic eg0, input logic eg1, input logic [31:0] resp);
        resp_t cur;
        resp_t nxt;
        cur = '0;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            cur = sb.pop_front();
        end
        sram_read_data = (cur.v0 | cur.v1) ? cur.d : 32'h5A5A_A5A5;
        if (rst) cur = '0;
        @(negedge clk);
        checkOutput(eg0, eg1, cur);
        nxt.v0 = eg0 & ~m0_we;
        nxt.v1 = eg1 & ~m1_we;
        nxt.d  = resp;
        sb.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        sram_read_data = '0;
        drive0(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        drive1(1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
        sb.push_back('0);
        @(posedge clk);
        #1;

        $display("[TB] reset with both requests");
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h1111_0001);
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 32'h2222_0002);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] single read requester 0");
        drive0(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        applyStimulus(1'b1, 1'b0, 32'hDEAD_BEEF);
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] write pass-through requester 1");
        drive1(1'b1, 1'b1, 32'h10, 32'h1234_5678, 4'b0011);
        applyStimulus(1'b0, 1'b1, 32'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] starvation bound");
        drive0(1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
        drive1(1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
        for (int k = 0; k < 10; k++) begin
            applyStimulus((k % 5) != 4, (k % 5) == 4, 32'hC000_0000 + 32'(k));
        end
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] interleaved reads");
        drive0(1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
        applyStimulus(1'b1, 1'b0, 32'h0000_000A);
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive1(1'b1, 1'b0, 32'h600, 32'h0, 4'hF);
        applyStimulus(1'b0, 1'b1, 32'h0000_000B);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] requester 1 drops at the wait limit");
        drive0(1'b1, 1'b1, 32'h700, 32'hAAAA_5555, 4'b1100);
        drive1(1'b1, 1'b0, 32'h800, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
        end
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        drive1(1'b1, 1'b0, 32'h800, 32'h0, 4'hF);
        applyStimulus(1'b1, 1'b0, 32'h0);
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] reset mid-read");
        drive1(1'b1, 1'b0, 32'h900, 32'h0, 4'hF);
        applyStimulus(1'b0, 1'b1, 32'hBAD0_0001);
        rst = 1'b1;
        drive0(1'b1, 1'b0, 32'hA00, 32'h0, 4'hF);
        applyStimulus(1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(k != 4, k == 4, 32'hE000_0000 + 32'(k));
        end
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_port_arbiter.md
# data_port_arbiter

Two-requester arbiter sharing the single-port data SRAM between the memory stage (requester 0) and a secondary master such as instruction fetch or a debug/DMA port (requester 1). The memory stage has priority by default. A wait counter guarantees requester 1 a grant after a bounded number of denied cycles. The block tracks which requester owns each in-flight read and routes the one-cycle-late read data back to that requester only.

## Interface
- ADDR_WIDTH, 32, SRAM byte address width
- DATA_WIDTH, 32, SRAM data width; BE_WIDTH = DATA_WIDTH/8
- MAX_WAIT, 4, consecutive denied cycles after which requester 1 wins; legal range ≥ 1
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- m0_req  in  1  requester 0 access request, held until granted
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_WIDTH  access address
- m0_wdata  in  DATA_WIDTH  write data
- m0_be  in  BE_WIDTH  byte enables
- m0_gnt  out  1  access accepted this cycle
- m0_rvalid  out  1  read data for requester 0 valid this cycle
- m0_rdata  out  DATA_WIDTH  read data; 0 when m0_rvalid = 0
- m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_gnt, m1_rvalid, m1_rdata: requester 1, same widths and meanings
- sram_enable  out  1  SRAM access strobe
- sram_write_enable  out  1  SRAM write strobe
- sram_address  out  ADDR_WIDTH  SRAM address
- sram_write_data  out  DATA_WIDTH  SRAM write data
- sram_byte_enable  out  BE_WIDTH  SRAM byte enables
- sram_read_data  in  DATA_WIDTH  SRAM read data, valid one cycle after a read strobe

## Operation
- Grant is combinational from m*_req and registered state. At most one of m0_gnt and m1_gnt is high.
- Priority: when wait_cnt == MAX_WAIT, requester 1 has priority. Otherwise requester 0 has priority.
- The winner's signals drive the SRAM: sram_enable = 1, sram_write_enable = m*_we, plus address, wdata and be.
- With no grant, all sram_* outputs are 0, except sram_byte_enable, which is all ones.
- wait_cnt, width $clog2(MAX_WAIT+1), registered:
  - cleared when m1_req = 0 or m1_gnt = 1;
  - else incremented when m1_req = 1 and m1_gnt = 0;
  - saturates at MAX_WAIT.
- Read tracking, registered: rd_pending <= granted & ~we; rd_owner <= index of granted requester.
- rd_owner holds its value when there is no read grant.
- m0_rvalid = rd_pending & (rd_owner == 0); m1_rvalid = rd_pending & (rd_owner == 1).
- m*_rdata = sram_read_data when the matching rvalid is high, else 0.
- Writes complete at grant and produce no rvalid.
- A requester whose m*_req is high and m*_gnt is low must hold all of its request signals stable. The memory-stage wrapper stalls its pipeline on ~m0_gnt.
- The arbiter does not buffer requests and does not check address conflicts.

## Timing
- Grant latency 0 cycles. Read data arrives 1 cycle after grant. Back-to-back grants are allowed every cycle.
- A read by one requester followed next cycle by a grant to the other is legal: the rvalid for cycle N+1 reflects the cycle-N grant only.
- Reset (rst = 1):
  - all gnt outputs 0 and all sram_* strobes 0 during that cycle;
  - rd_pending = 0, rd_owner = 0, wait_cnt = 0 after the edge.
- A read granted in the cycle before rst is asserted has its response dropped: rvalid stays 0.
- Simultaneous requests with wait_cnt < MAX_WAIT: requester 0 is granted and wait_cnt increments.
- Simultaneous requests with wait_cnt == MAX_WAIT: requester 1 is granted, wait_cnt clears, and requester 0 stalls one cycle.
- If m1_req drops while wait_cnt == MAX_WAIT, the counter clears and priority returns to requester 0 in the next cycle.

## Test plan
- Reset and idle:
  - stimulus: rst high for 2 cycles with m0_req = m1_req = 1;
  - required: m0_gnt = m1_gnt = 0 and sram_enable = 0 during reset; after release, requester 0 is granted first.
- Single read, requester 0:
  - stimulus: m0_req, we = 0, addr 0x40; SRAM returns 0xDEADBEEF next cycle;
  - required: m0_gnt = 1 in cycle N; m0_rvalid = 1 with m0_rdata = 0xDEADBEEF in cycle N+1; m1_rvalid = 0 and m1_rdata = 0.
- Write pass-through, requester 1:
  - stimulus: m1 write, addr 0x10, wdata 0x12345678, be 4'b0011, m0 idle;
  - required: same-cycle sram_write_enable = 1 with identical address/data/be; no rvalid next cycle.
- Starvation bound (MAX_WAIT = 4):
  - stimulus: both requests held continuously;
  - required: grant pattern m0,m0,m0,m0,m1 repeating; m1 granted in exactly every 5th cycle.
- Interleaved reads:
  - stimulus: m0 read at cycle N, m1 read at cycle N+1, SRAM data 0xA then 0xB;
  - required: m0_rvalid/0xA at N+1, m1_rvalid/0xB at N+2, never both high.
- Reset mid-read:
  - stimulus: m1 read granted at cycle N, rst = 1 at cycle N+1;
  - required: m1_rvalid = 0 at N+1 and after; wait_cnt = 0 after the reset edge.
